// File: rtl/aes_cipher_iter.sv
// Iterative AES forward cipher: one round per clock over a shared round datapath,
// consuming a flat, externally held round-key schedule of nr+1 keys.
module aes_cipher_iter #(
    parameter int nr = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     ready,
    input  logic [0:127]             in_block,
    input  logic [0:128*(nr+1)-1]    keyschedule,
    output logic [0:127]             out_block,
    output logic                     out_valid
);

    localparam logic [3:0] last_round = 4'(nr);

    // FIPS-197 S-box, byte v at bits v*8 +: 8
    localparam logic [0:2047] sbox_table = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return sbox_table[int'(b)*8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t         fsm_reg, fsm_next;
    logic [3:0]   round_reg, round_next;
    logic [0:127] data_reg, data_next;
    logic [0:127] out_block_reg, out_block_next;
    logic         out_valid_reg, out_valid_next;
    logic         ready_reg, ready_next;

    logic [0:127] rk_arr [0:15];
    logic [0:127] rk_sel;
    logic [0:127] sr_bytes;
    logic [0:127] mc_bytes;

    // Unused slots read as zero so any 4-bit counter value indexes safely
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_rk
            if (gi <= nr) begin : g_used
                assign rk_arr[gi] = keyschedule[gi*128 +: 128];
            end else begin : g_unused
                assign rk_arr[gi] = '0;
            end
        end
    endgenerate

    assign rk_sel = rk_arr[round_reg];

    // SubBytes fused with ShiftRows: output byte (row, col) comes from column col+row
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sbsr
            localparam int row = gi % 4;
            localparam int col = gi / 4;
            localparam int src = row + 4 * ((col + row) % 4);
            assign sr_bytes[gi*8 +: 8] = sub_byte(data_reg[src*8 +: 8]);
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mix
            logic [7:0] a0, a1, a2, a3;
            assign a0 = sr_bytes[(4*gi+0)*8 +: 8];
            assign a1 = sr_bytes[(4*gi+1)*8 +: 8];
            assign a2 = sr_bytes[(4*gi+2)*8 +: 8];
            assign a3 = sr_bytes[(4*gi+3)*8 +: 8];
            assign mc_bytes[(4*gi+0)*8 +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            assign mc_bytes[(4*gi+1)*8 +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            assign mc_bytes[(4*gi+2)*8 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            assign mc_bytes[(4*gi+3)*8 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    endgenerate

    always_comb begin
        fsm_next       = fsm_reg;
        round_next     = round_reg;
        data_next      = data_reg;
        out_block_next = out_block_reg;
        out_valid_next = 1'b0;
        ready_next     = ready_reg;
        case (fsm_reg)
            IDLE: begin
                ready_next = 1'b1;
                if (start && ready_reg) begin
                    data_next  = in_block ^ rk_arr[0];
                    round_next = 4'd1;
                    fsm_next   = RUN;
                    ready_next = 1'b0;
                end
            end
            RUN: begin
                if (round_reg == 4'd0 || round_reg > last_round) begin
                    fsm_next   = IDLE;
                    round_next = 4'd0;
                    ready_next = 1'b1;
                end else if (round_reg == last_round) begin
                    out_block_next = sr_bytes ^ rk_sel;
                    out_valid_next = 1'b1;
                    ready_next     = 1'b1;
                    fsm_next       = IDLE;
                    round_next     = 4'd0;
                end else begin
                    data_next  = mc_bytes ^ rk_sel;
                    round_next = round_reg + 4'd1;
                end
            end
            default: begin
                fsm_next   = IDLE;
                round_next = 4'd0;
                ready_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg       <= IDLE;
            round_reg     <= 4'd0;
            data_reg      <= '0;
            out_block_reg <= '0;
            out_valid_reg <= 1'b0;
            ready_reg     <= 1'b1;
        end else begin
            fsm_reg       <= fsm_next;
            round_reg     <= round_next;
            data_reg      <= data_next;
            out_block_reg <= out_block_next;
            out_valid_reg <= out_valid_next;
            ready_reg     <= ready_next;
        end
    end

    assign ready     = ready_reg;
    assign out_block = out_block_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: known-answer table, randomized blocks against an
// algebraic AES model, and hand-written back-to-back / start-poke / reset sequences.
module tb_aes_cipher_iter;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [0:127]   in_block;
    logic [0:1919]  ks_all;
    int             sel_nr;

    logic           start10, start12, start14;
    logic           ready10, ready12, ready14;
    logic           ov10, ov12, ov14;
    logic [0:127]   ob10, ob12, ob14;
    logic           cur_ready, cur_valid;
    logic [0:127]   cur_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sbox_t [256];

    always #5 clk = ~clk;

    assign start10 = start && (sel_nr == 10);
    assign start12 = start && (sel_nr == 12);
    assign start14 = start && (sel_nr == 14);

    aes_cipher_iter #(.nr(10)) dut10 (
        .clk(clk), .rst(rst), .start(start10), .ready(ready10), .in_block(in_block),
        .keyschedule(ks_all[0:1407]), .out_block(ob10), .out_valid(ov10));
    aes_cipher_iter #(.nr(12)) dut12 (
        .clk(clk), .rst(rst), .start(start12), .ready(ready12), .in_block(in_block),
        .keyschedule(ks_all[0:1663]), .out_block(ob12), .out_valid(ov12));
    aes_cipher_iter #(.nr(14)) dut14 (
        .clk(clk), .rst(rst), .start(start14), .ready(ready14), .in_block(in_block),
        .keyschedule(ks_all[0:1919]), .out_block(ob14), .out_valid(ov14));

    always_comb begin
        cur_ready = ready10;
        cur_valid = ov10;
        cur_out   = ob10;
        case (sel_nr)
            12: begin cur_ready = ready12; cur_valid = ov12; cur_out = ob12; end
            14: begin cur_ready = ready14; cur_valid = ov14; cur_out = ob14; end
            default: ;
        endcase
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        logic [7:0] r = v;
        for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from the multiplicative inverse in GF(2^8) plus the affine map
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic int nk_of(input int n);
        return (n == 10) ? 4 : (n == 12) ? 6 : 8;
    endfunction

    function automatic logic [0:1919] key_expand(input logic [0:255] key, input int n);
        logic [31:0]   w [0:59];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [0:1919] ks = '0;
        int            nk = nk_of(n);
        for (int i = 0; i < 4 * (n + 1); i++) begin
            if (i < nk) begin
                w[i] = key[i*32 +: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xt(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subword(t);
                end
                w[i] = w[i-nk] ^ t;
            end
            ks[i*32 +: 32] = w[i];
        end
        return ks;
    endfunction

    function automatic logic [0:127] aes_model(input logic [0:1919] ks, input int n,
                                               input logic [0:127] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [0:127] r;
        for (int i = 0; i < 16; i++) s[i] = pt[i*8 +: 8] ^ ks[i*8 +: 8];
        for (int rd = 1; rd <= n; rd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) t[rw + 4*c] = s[rw + 4*((c + rw) % 4)];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++)
                    if (rd < n)
                        s[4*c+rw] = gmul(8'h02, t[4*c+rw]) ^ gmul(8'h03, t[4*c+(rw+1)%4])
                                  ^ t[4*c+(rw+2)%4] ^ t[4*c+(rw+3)%4];
                    else
                        s[4*c+rw] = t[4*c+rw];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[(rd*16 + i)*8 +: 8];
        end
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = s[i];
        return r;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s nr=%0d: got %h required %h", name, sel_nr, act, exp);
        end
    endtask

    function automatic logic [0:127] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [0:255] rand256();
        return {rand128(), rand128()};
    endfunction

    // Runs one block; 'chained' means start was already raised in the previous valid cycle.
    task automatic run_block(input int n, input logic [0:127] pt, input logic [0:127] exp,
                             input string name, input bit chained, input bit poke,
                             input bit chain_next, input logic [0:127] next_pt);
        int edges;
        int low;
        if (!chained) begin
            @(negedge clk);
            in_block = pt;
            start    = 1'b1;
        end
        @(posedge clk); #1;
        edges = 1;
        low   = cur_ready ? 0 : 1;
        check({name, "_valid_after_start"}, 128'(cur_valid), 128'(0));
        check({name, "_ready_after_start"}, 128'(cur_ready), 128'(0));
        in_block = rand128();
        start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
        while (!cur_valid && edges < n + 6) begin
            @(posedge clk); #1;
            edges++;
            if (!cur_valid && !cur_ready) low++;
            in_block = rand128();
            start    = (poke && !cur_valid) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        check({name, "_latency"}, 128'(edges), 128'(n + 1));
        check({name, "_ready_low_cycles"}, 128'(low), 128'(n));
        check({name, "_ciphertext"}, cur_out, exp);
        $display("txn %s nr=%0d pt=%h ct=%h exp=%h edges=%0d", name, n, pt, cur_out, exp, edges);
        if (chain_next) begin
            start    = 1'b1;
            in_block = next_pt;
        end else begin
            @(posedge clk); #1;
            check({name, "_pulse_width"}, 128'(cur_valid), 128'(0));
            check({name, "_out_hold"}, cur_out, exp);
        end
    endtask

    typedef struct {
        int           n;
        logic [0:255] key;
        logic [0:127] pt;
        logic [0:127] ct;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [0:255] key;
        logic [0:127] pt;
        logic [0:127] exp;
        bit           seen;

        vecs[0] = '{10, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{10, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{12, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                    128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
        vecs[3] = '{14, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089};

        build_sbox();
        rst      = 1'b1;
        start    = 1'b0;
        in_block = '0;
        ks_all   = '0;
        sel_nr   = 10;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            sel_nr = 10 + 2 * k;
            #1;
            check("reset_ready", 128'(cur_ready), 128'(1));
            check("reset_valid", 128'(cur_valid), 128'(0));
            check("reset_out", cur_out, 128'(0));
        end
        @(negedge clk);
        rst = 1'b0;

        // Known-answer table
        for (int v = 0; v < 4; v++) begin
            sel_nr = vecs[v].n;
            ks_all = key_expand(vecs[v].key, vecs[v].n);
            run_block(vecs[v].n, vecs[v].pt, vecs[v].ct, $sformatf("kat%0d", v), 1'b0, 1'b0, 1'b0, '0);
        end

        // Back-to-back: second start in the out_valid cycle
        sel_nr = 10;
        ks_all = key_expand(vecs[1].key, 10);
        exp    = aes_model(ks_all, 10, vecs[0].pt);
        run_block(10, vecs[1].pt, vecs[1].ct, "b2b_first", 1'b0, 1'b0, 1'b1, vecs[0].pt);
        run_block(10, vecs[0].pt, exp, "b2b_second", 1'b1, 1'b0, 1'b0, '0);

        // Start pulses while running must be ignored
        sel_nr = 12;
        key    = rand256();
        pt     = rand128();
        ks_all = key_expand(key, 12);
        run_block(12, pt, aes_model(ks_all, 12, pt), "poke", 1'b0, 1'b1, 1'b0, '0);

        // Randomized blocks for every key size
        for (int k = 0; k < 3; k++) begin
            sel_nr = 10 + 2 * k;
            for (int j = 0; j < 3; j++) begin
                key    = rand256();
                pt     = rand128();
                ks_all = key_expand(key, sel_nr);
                run_block(sel_nr, pt, aes_model(ks_all, sel_nr, pt), $sformatf("rand%0d_%0d", sel_nr, j),
                          1'b0, 1'b0, 1'b0, '0);
            end
        end

        // Reset in the middle of a block
        sel_nr = 10;
        ks_all = key_expand(vecs[0].key, 10);
        @(negedge clk);
        in_block = vecs[1].pt;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready", 128'(cur_ready), 128'(1));
        check("midrst_valid", 128'(cur_valid), 128'(0));
        check("midrst_out", cur_out, 128'(0));
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (cur_valid) seen = 1'b1;
        end
        check("midrst_no_stale_pulse", 128'(seen), 128'(0));
        $display("txn midrst nr=10 ready=%0d out=%h", cur_ready, cur_out);
        run_block(10, vecs[0].pt, vecs[0].ct, "after_midrst", 1'b0, 1'b0, 1'b0, '0);

        // Reset and start together: reset wins
        @(negedge clk);
        rst      = 1'b1;
        start    = 1'b1;
        in_block = vecs[1].pt;
        @(posedge clk); #1;
        check("rststart_ready", 128'(cur_ready), 128'(1));
        check("rststart_valid", 128'(cur_valid), 128'(0));
        check("rststart_out", cur_out, 128'(0));
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        seen  = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (cur_valid) seen = 1'b1;
        end
        check("rststart_no_pulse", 128'(seen), 128'(0));
        $display("txn rststart nr=10 ready=%0d out=%h", cur_ready, cur_out);
        run_block(10, vecs[0].pt, vecs[0].ct, "after_rststart", 1'b0, 1'b0, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
